// File: rtl/sp_bram_pkg.sv
// Shared encodings, state constants and init-pattern helper for the
// parametrised single-port block RAM.
package sp_bram_pkg;

    localparam int RM_BYPASS   = 0;
    localparam int RM_PIPELINE = 1;

    localparam int WM_NORMAL            = 0;
    localparam int WM_WRITE_THROUGH     = 1;
    localparam int WM_READ_BEFORE_WRITE = 2;

    localparam int INIT_ZERO = 0;
    localparam int INIT_DESC = 1;
    localparam int INIT_ASC  = 2;

    localparam int MAX_DATA_W = 36;

    typedef logic [0:0] state_t;
    localparam state_t ST_FILL  = 1'b0;
    localparam state_t ST_READY = 1'b1;

    // Widest possible pattern word; callers truncate to their own DATA_W.
    function automatic logic [MAX_DATA_W-1:0] init_word(
        input int unsigned idx,
        input int unsigned depth,
        input int          mode
    );
        logic [MAX_DATA_W-1:0] w;
        w = '0;
        case (mode)
            INIT_DESC: w = MAX_DATA_W'(depth - 1 - idx);
            INIT_ASC:  w = MAX_DATA_W'(idx);
            default:   w = '0;
        endcase
        return w;
    endfunction

    function automatic int be_width(input int data_w);
        return (data_w % 8 == 0) ? data_w / 8 : 1;
    endfunction

endpackage

// File: rtl/sp_bram_core.sv
// Byte-enabled storage array with a registered, read-before-write read port.
// Byte-granular widths are split into one 8-bit array per lane.
module sp_bram_core
    import sp_bram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int BE_W   = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] ad,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (DATA_W % 8 == 0 && BE_W == DATA_W / 8) begin : g_bytes
            for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
                logic [7:0] lane_mem [0:DEPTH-1];
                logic [7:0] lane_rd_reg;

                always_ff @(posedge clk) begin
                    if (we && be[gi]) begin
                        lane_mem[ad] <= din[gi*8 +: 8];
                    end
                    if (rd_en) begin
                        lane_rd_reg <= lane_mem[ad];
                    end
                end

                assign rd_data[gi*8 +: 8] = lane_rd_reg;
            end
        end else begin : g_word
            // Non-byte widths have a single enable covering the whole word.
            logic [DATA_W-1:0] mem [0:DEPTH-1];
            logic [DATA_W-1:0] rd_reg;

            always_ff @(posedge clk) begin
                if (we && be[0]) begin
                    mem[ad] <= din;
                end
                if (rd_en) begin
                    rd_reg <= mem[ad];
                end
            end

            assign rd_data = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/sp_bram_param.sv
// Single-port block RAM with init fill sequencer, write-mode result mux and
// optional oce-gated output register.
module sp_bram_param
    import sp_bram_pkg::*;
#(
    parameter int  DATA_W     = 8,
    parameter int  ADDR_W     = 4,
    parameter int  READ_MODE  = RM_BYPASS,
    parameter int  WRITE_MODE = WM_NORMAL,
    parameter int  INIT_MODE  = INIT_DESC,
    localparam int BE_W       = (DATA_W % 8 == 0) ? DATA_W / 8 : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              oce,
    input  logic              wre,
    input  logic [ADDR_W-1:0] ad,
    input  logic [DATA_W-1:0] din,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              busy
);

    localparam int unsigned   DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    logic              filling;
    logic              accept;
    logic [DATA_W-1:0] fill_word;

    logic              core_we;
    logic [BE_W-1:0]   core_be;
    logic [ADDR_W-1:0] core_ad;
    logic [DATA_W-1:0] core_din;
    logic [DATA_W-1:0] rd_data;

    logic              load_reg, load_next;
    logic              merge_reg, merge_next;
    logic [DATA_W-1:0] din_reg;
    logic [BE_W-1:0]   be_reg;
    logic [DATA_W-1:0] be_mask;
    logic [DATA_W-1:0] s1_data;
    logic [DATA_W-1:0] s1_hold_reg;

    // ---------------- fill sequencer ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_FILL) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_ADDR) begin
                state_next = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_FILL;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy      = (state_reg == ST_FILL);
    assign filling   = busy & ~reset;
    assign accept    = ce & ~busy & ~reset;
    assign fill_word = DATA_W'(init_word(32'(cnt_reg), DEPTH, INIT_MODE));

    // The sequencer owns the array port while filling; user inputs are ignored.
    assign core_we  = filling | (accept & wre);
    assign core_be  = filling ? {BE_W{1'b1}} : be;
    assign core_ad  = filling ? cnt_reg : ad;
    assign core_din = filling ? fill_word : din;

    sp_bram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_core (
        .clk     (clk),
        .we      (core_we),
        .be      (core_be),
        .ad      (core_ad),
        .din     (core_din),
        .rd_en   (accept),
        .rd_data (rd_data)
    );

    // ---------------- stage-1 result ----------------
    // Normal-mode writes leave stage-1 untouched; every other access reloads it.
    assign load_next  = accept & (~wre | (WRITE_MODE != WM_NORMAL));
    assign merge_next = accept & wre & (WRITE_MODE == WM_WRITE_THROUGH);

    always_ff @(posedge clk) begin
        if (reset) begin
            load_reg    <= 1'b0;
            merge_reg   <= 1'b0;
            s1_hold_reg <= '0;
        end else begin
            load_reg    <= load_next;
            merge_reg   <= merge_next;
            s1_hold_reg <= s1_data;
        end
        if (accept) begin
            din_reg <= din;
            be_reg  <= be;
        end
    end

    generate
        if (DATA_W % 8 == 0) begin : g_mask_bytes
            for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
                assign be_mask[gi*8 +: 8] = {8{be_reg[gi]}};
            end
        end else begin : g_mask_word
            assign be_mask = {DATA_W{be_reg[0]}};
        end
    endgenerate

    // Write-through merges the new bytes over the old word read on the same edge.
    always_comb begin
        s1_data = s1_hold_reg;
        if (load_reg) begin
            if (merge_reg) begin
                s1_data = (rd_data & ~be_mask) | (din_reg & be_mask);
            end else begin
                s1_data = rd_data;
            end
        end
    end

    // ---------------- output stage ----------------
    generate
        if (READ_MODE == RM_PIPELINE) begin : g_pipe
            logic [DATA_W-1:0] dout_reg;
            logic              rd_valid_reg;
            logic              pend_reg;
            logic              s1_valid;

            // A stage-1 result stays pending until oce transfers it out.
            assign s1_valid = load_reg | pend_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_reg     <= '0;
                    rd_valid_reg <= 1'b0;
                    pend_reg     <= 1'b0;
                end else begin
                    rd_valid_reg <= s1_valid & oce;
                    pend_reg     <= s1_valid & ~oce;
                    if (oce) begin
                        dout_reg <= s1_data;
                    end
                end
            end

            assign dout     = dout_reg;
            assign rd_valid = rd_valid_reg;
        end else begin : g_bypass
            logic unused_oce;
            assign unused_oce = oce;
            assign dout       = s1_data;
            assign rd_valid   = load_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sp_bram_param.sv
// Self-checking bench: five configurations, vector table, hand sequences and
// a randomized run against a behavioural memory model.
module tb_sp_bram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // group A drives three 8-bit instances differing only in WRITE_MODE
    logic       ce_a, wre_a, oce_a;
    logic [3:0] ad_a;
    logic [7:0] din_a;
    logic [0:0] be_a;
    logic [7:0] dout_def, dout_wm1, dout_wm2;
    logic       rv_def, rv_wm1, rv_wm2, busy_def, busy_wm1, busy_wm2;

    logic        ce_b, wre_b, oce_b;
    logic [3:0]  ad_b;
    logic [15:0] din_b, dout_b;
    logic [1:0]  be_b;
    logic        rv_b, busy_b;

    logic       ce_p, wre_p, oce_p;
    logic [3:0] ad_p;
    logic [7:0] din_p, dout_p;
    logic [0:0] be_p;
    logic       rv_p, busy_p;

    sp_bram_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(0), .INIT_MODE(1)) u_def (
        .clk(clk), .reset(reset), .ce(ce_a), .oce(oce_a), .wre(wre_a), .ad(ad_a),
        .din(din_a), .be(be_a), .dout(dout_def), .rd_valid(rv_def), .busy(busy_def));

    sp_bram_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(1), .INIT_MODE(1)) u_wm1 (
        .clk(clk), .reset(reset), .ce(ce_a), .oce(oce_a), .wre(wre_a), .ad(ad_a),
        .din(din_a), .be(be_a), .dout(dout_wm1), .rd_valid(rv_wm1), .busy(busy_wm1));

    sp_bram_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(2), .INIT_MODE(1)) u_wm2 (
        .clk(clk), .reset(reset), .ce(ce_a), .oce(oce_a), .wre(wre_a), .ad(ad_a),
        .din(din_a), .be(be_a), .dout(dout_wm2), .rd_valid(rv_wm2), .busy(busy_wm2));

    sp_bram_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(0), .INIT_MODE(1)) u_be (
        .clk(clk), .reset(reset), .ce(ce_b), .oce(oce_b), .wre(wre_b), .ad(ad_b),
        .din(din_b), .be(be_b), .dout(dout_b), .rd_valid(rv_b), .busy(busy_b));

    sp_bram_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1), .WRITE_MODE(0), .INIT_MODE(1)) u_pipe (
        .clk(clk), .reset(reset), .ce(ce_p), .oce(oce_p), .wre(wre_p), .ad(ad_p),
        .din(din_p), .be(be_p), .dout(dout_p), .rd_valid(rv_p), .busy(busy_p));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       ce;
        logic       wre;
        logic [3:0] ad;
        logic [7:0] din;
        logic       be;
        logic [7:0] exp_dout;
        logic       exp_valid;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic w, input logic [3:0] a,
                                input logic [7:0] d, input logic b,
                                input logic [7:0] ed, input logic ev);
        vec_t v;
        v.ce = c; v.wre = w; v.ad = a; v.din = d; v.be = b;
        v.exp_dout = ed; v.exp_valid = ev;
        return v;
    endfunction

    vec_t       tbl [10];
    logic [7:0] mem_m [16];
    logic [7:0] exp_d [3];
    logic       exp_v [3];
    logic [7:0] act_d [3];
    logic       act_v [3];

    initial begin
        reset = 1'b1;
        ce_a = 1'b0; wre_a = 1'b0; oce_a = 1'b0; ad_a = '0; din_a = '0; be_a = 1'b1;
        ce_b = 1'b0; wre_b = 1'b0; oce_b = 1'b0; ad_b = '0; din_b = '0; be_b = 2'b11;
        ce_p = 1'b0; wre_p = 1'b0; oce_p = 1'b1; ad_p = '0; din_p = '0; be_p = 1'b1;

        tbl[0] = mk(1, 0, 4'd0,  8'h00, 1, 8'h0F, 1);
        tbl[1] = mk(1, 0, 4'd15, 8'h00, 1, 8'h00, 1);
        tbl[2] = mk(1, 0, 4'd3,  8'h00, 1, 8'h0C, 1);
        tbl[3] = mk(1, 1, 4'd4,  8'h77, 1, 8'h0C, 0);
        tbl[4] = mk(1, 0, 4'd4,  8'h00, 1, 8'h77, 1);
        tbl[5] = mk(1, 0, 4'd5,  8'h00, 1, 8'h0A, 1);
        tbl[6] = mk(0, 0, 4'd5,  8'h00, 1, 8'h0A, 0);
        tbl[7] = mk(1, 1, 4'd6,  8'h99, 0, 8'h0A, 0);
        tbl[8] = mk(1, 0, 4'd6,  8'h00, 1, 8'h09, 1);
        tbl[9] = mk(1, 0, 4'd14, 8'h00, 1, 8'h01, 1);

        // ---- reset and initial fill, with a write attempt while busy ----
        tick;
        tick;
        check("reset_dout", 32'(dout_def), 32'h0);
        check("reset_busy", 32'(busy_def), 32'h1);
        reset = 1'b0;
        ce_a = 1'b1; wre_a = 1'b1; ad_a = 4'd3; din_a = 8'hAA;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill_busy_%0d", i), 32'(busy_def), 32'h1);
            check($sformatf("fill_dout_%0d", i), 32'(dout_def), 32'h0);
            check($sformatf("fill_rv_%0d", i), 32'(rv_def), 32'h0);
            tick;
        end
        check("fill_done_def", 32'(busy_def), 32'h0);
        check("fill_done_be", 32'(busy_b), 32'h0);
        check("fill_done_pipe", 32'(busy_p), 32'h0);
        $display("txn fill: busy dropped after 16 cycles");
        ce_a = 1'b0;

        // ---- vector table on the default instance ----
        for (int i = 0; i < 10; i++) begin
            ce_a = tbl[i].ce; wre_a = tbl[i].wre; ad_a = tbl[i].ad;
            din_a = tbl[i].din; be_a = tbl[i].be;
            tick;
            $display("txn tbl%0d ce=%0d wre=%0d ad=%0d din=%02h be=%0d -> dout=%02h rv=%0d",
                     i, tbl[i].ce, tbl[i].wre, tbl[i].ad, tbl[i].din, tbl[i].be, dout_def, rv_def);
            check($sformatf("tbl%0d_dout", i), 32'(dout_def), 32'(tbl[i].exp_dout));
            check($sformatf("tbl%0d_rv", i), 32'(rv_def), 32'(tbl[i].exp_valid));
        end
        ce_a = 1'b0; be_a = 1'b1;

        // ---- write modes: ad 5 holds 0x0A ----
        ce_a = 1'b1; wre_a = 1'b1; ad_a = 4'd5; din_a = 8'h55;
        tick;
        $display("txn wmode write ad=5 din=55 -> wm0=%02h wm1=%02h wm2=%02h", dout_def, dout_wm1, dout_wm2);
        check("wm1_dout", 32'(dout_wm1), 32'h55);
        check("wm1_rv", 32'(rv_wm1), 32'h1);
        check("wm2_dout", 32'(dout_wm2), 32'h0A);
        check("wm2_rv", 32'(rv_wm2), 32'h1);
        check("wm0_dout_hold", 32'(dout_def), 32'h01);
        check("wm0_rv", 32'(rv_def), 32'h0);
        wre_a = 1'b0;
        tick;
        $display("txn wmode read ad=5 -> wm0=%02h wm1=%02h wm2=%02h", dout_def, dout_wm1, dout_wm2);
        check("wm0_readback", 32'(dout_def), 32'h55);
        check("wm1_readback", 32'(dout_wm1), 32'h55);
        check("wm2_readback", 32'(dout_wm2), 32'h55);
        ce_a = 1'b0;

        // ---- byte enables on the 16-bit instance ----
        ce_b = 1'b1; wre_b = 1'b0; ad_b = 4'd0;
        tick;
        $display("txn be read ad=0 -> %04h", dout_b);
        check("be_rd0", 32'(dout_b), 32'h000F);
        wre_b = 1'b1; ad_b = 4'd2; din_b = 16'hBEEF; be_b = 2'b10;
        tick;
        $display("txn be write ad=2 din=BEEF be=10 -> %04h rv=%0d", dout_b, rv_b);
        check("be_wr_hold", 32'(dout_b), 32'h000F);
        check("be_wr_rv", 32'(rv_b), 32'h0);
        wre_b = 1'b0; be_b = 2'b11;
        tick;
        $display("txn be read ad=2 -> %04h", dout_b);
        check("be_rd2", 32'(dout_b), 32'hBE0D);
        check("be_rd2_rv", 32'(rv_b), 32'h1);
        ce_b = 1'b0;

        // ---- pipeline, oce held high ----
        oce_p = 1'b1; ce_p = 1'b1; wre_p = 1'b0; ad_p = 4'd0;
        tick;
        check("pipe_lat_rv", 32'(rv_p), 32'h0);
        ad_p = 4'd1;
        tick;
        $display("txn pipe rd0 -> %02h rv=%0d", dout_p, rv_p);
        check("pipe_rd0", 32'(dout_p), 32'h0F);
        check("pipe_rd0_rv", 32'(rv_p), 32'h1);
        ce_p = 1'b0;
        tick;
        $display("txn pipe rd1 -> %02h rv=%0d", dout_p, rv_p);
        check("pipe_rd1", 32'(dout_p), 32'h0E);
        check("pipe_rd1_rv", 32'(rv_p), 32'h1);
        tick;
        check("pipe_idle_rv", 32'(rv_p), 32'h0);

        // ---- pipeline, oce stalled for 3 cycles after the second read ----
        ce_p = 1'b1; ad_p = 4'd0;
        tick;
        ad_p = 4'd1;
        tick;
        check("stall_rd0", 32'(dout_p), 32'h0F);
        check("stall_rd0_rv", 32'(rv_p), 32'h1);
        ce_p = 1'b0; oce_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            $display("txn pipe stall %0d -> %02h rv=%0d", i, dout_p, rv_p);
            check($sformatf("stall%0d_dout", i), 32'(dout_p), 32'h0F);
            check($sformatf("stall%0d_rv", i), 32'(rv_p), 32'h0);
        end
        oce_p = 1'b1;
        tick;
        $display("txn pipe release -> %02h rv=%0d", dout_p, rv_p);
        check("release_dout", 32'(dout_p), 32'h0E);
        check("release_rv", 32'(rv_p), 32'h1);
        tick;
        check("release_once", 32'(rv_p), 32'h0);
        check("release_hold", 32'(dout_p), 32'h0E);

        // ---- reset while ready, then reset again at fill cycle 7 ----
        reset = 1'b1;
        tick;
        check("rst_ready_dout", 32'(dout_def), 32'h0);
        check("rst_ready_busy", 32'(busy_def), 32'h1);
        check("rst_pipe_dout", 32'(dout_p), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("refill_busy_%0d", i), 32'(busy_def), 32'h1);
            tick;
        end
        check("refill_done", 32'(busy_def), 32'h0);
        ce_a = 1'b1; wre_a = 1'b0; ad_a = 4'd7;
        tick;
        $display("txn refill read ad=7 -> %02h", dout_def);
        check("refill_rd7", 32'(dout_def), 32'h08);
        ad_a = 4'd4;
        tick;
        $display("txn refill read ad=4 -> %02h", dout_def);
        check("refill_rd4", 32'(dout_def), 32'h0B);
        ce_a = 1'b0;

        // ---- randomized traffic against the memory model ----
        for (int i = 0; i < 16; i++) mem_m[i] = 8'(15 - i);
        for (int m = 0; m < 3; m++) begin
            exp_d[m] = 8'h0B;
            exp_v[m] = 1'b0;
        end
        for (int t = 0; t < 300; t++) begin
            logic [7:0] old_w;
            ce_a  = ($urandom_range(0, 3) != 0);
            wre_a = 1'($urandom_range(0, 1));
            ad_a  = 4'($urandom_range(0, 15));
            din_a = 8'($urandom);
            be_a  = 1'($urandom_range(0, 1));
            old_w = mem_m[ad_a];
            for (int m = 0; m < 3; m++) exp_v[m] = 1'b0;
            if (ce_a && !wre_a) begin
                for (int m = 0; m < 3; m++) begin
                    exp_d[m] = old_w;
                    exp_v[m] = 1'b1;
                end
            end else if (ce_a && wre_a) begin
                exp_d[1] = be_a[0] ? din_a : old_w;
                exp_v[1] = 1'b1;
                exp_d[2] = old_w;
                exp_v[2] = 1'b1;
                if (be_a[0]) mem_m[ad_a] = din_a;
            end
            tick;
            act_d[0] = dout_def; act_d[1] = dout_wm1; act_d[2] = dout_wm2;
            act_v[0] = rv_def;   act_v[1] = rv_wm1;   act_v[2] = rv_wm2;
            $display("txn rnd%0d ce=%0d wre=%0d ad=%0d din=%02h be=%0d -> %02h/%02h/%02h",
                     t, ce_a, wre_a, ad_a, din_a, be_a, act_d[0], act_d[1], act_d[2]);
            for (int m = 0; m < 3; m++) begin
                check($sformatf("rnd%0d_wm%0d_dout", t, m), 32'(act_d[m]), 32'(exp_d[m]));
                check($sformatf("rnd%0d_wm%0d_rv", t, m), 32'(act_v[m]), 32'(exp_v[m]));
            end
        end
        ce_a = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_bram_param.md
Name: sp_bram_param

Overview:
- Parametrised single-port block-RAM with a synchronous read port and per-byte write enables.
- Successor to the fixed 16x8 Gowin SP wrapper, generalised in width, depth, read mode and write mode.
- Adds a built-in initialisation sequencer, a busy flag and a read-valid strobe.
- Sits between the system bus adapter and on-chip storage.

Parameters:
- DATA_W, 8, data word width in bits (1..36).
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- READ_MODE, 0, 0 = bypass (1-cycle read latency), 1 = pipeline (2-cycle, extra output register gated by oce).
- WRITE_MODE, 0, 0 = normal (dout holds on write), 1 = write-through, 2 = read-before-write.
- INIT_MODE, 1, fill pattern after reset: 0 = all zeros, 1 = descending (word[i] = DEPTH-1-i, truncated to DATA_W), 2 = ascending (word[i] = i).
- BE_W, derived: DATA_W/8 when DATA_W%8==0, else 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  access enable; ignored while busy.
- oce  in  1  output-register enable; used only when READ_MODE=1.
- wre  in  1  1 = write, 0 = read (qualified by ce).
- ad  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- be  in  BE_W  byte write enables; bit k covers din[8k+7:8k].
- dout  out  DATA_W  read data.
- rd_valid  out  1  dout carries a new result this cycle.
- busy  out  1  initialisation fill in progress.

Behaviour:
- Reset (sync, active-high): dout=0, rd_valid=0, busy=1, FSM enters FILL with fill counter 0; the pipeline register is cleared. Memory contents are not cleared by reset itself.
- FSM FILL:
  - each cycle writes the pattern word to mem[cnt] and increments cnt.
  - after writing cnt = DEPTH-1, moves to READY; busy drops the same edge.
  - fill takes exactly DEPTH cycles; busy is low on the first cycle after the final write.
- Reset asserted mid-fill restarts the fill at cnt 0. Reset in READY re-runs the fill.
- FILL ignores ce/wre/ad/din; no user access is accepted and dout is unchanged.
- READY, accepted access = ce & ~busy at the edge.
- Write (wre=1): mem[ad] byte k <= din byte k for each be[k]=1; other bytes keep their old value. be=0 writes nothing but still counts as an access.
- Write effect on dout (stage-1 result), by WRITE_MODE:
  - 0: dout holds its previous value.
  - 1: dout takes the merged new word.
  - 2: dout takes the old word.
- Read (wre=0): stage-1 result = mem[ad] as it was before the edge.
- READ_MODE=0: stage-1 drives dout; rd_valid=1 for one cycle after each accepted read, and after writes in WRITE_MODE 1/2; oce is ignored.
- READ_MODE=1: the stage-1 register loads every accepted access. The output register loads from stage-1 only when oce=1; if oce=0, dout and rd_valid hold.
  - rd_valid = stage-1 valid & oce, registered, so latency is 2 cycles with oce held high.
- Back-to-back accesses are allowed every cycle; no bubbles.
- ce=0: stage-1 holds its data, and its valid clears.

Decomposition:
- Shared package sp_bram_pkg holds:
  - the READ_MODE and WRITE_MODE encodings;
  - the INIT_MODE encodings;
  - the state typedef {FILL, READY};
  - a function computing the init word for an index.
- One sub-module, sp_bram_core: the byte-enabled storage array with the raw synchronous read (inferred BSRAM).
- The sequencer, write-mode mux and output pipeline live in the top.

Test Plan:
- Reset, defaults (8x16, INIT_MODE=1): busy high for exactly 16 cycles after reset release; dout=0 and rd_valid=0 throughout. Then read ad=0 -> 0x0F; ad=15 -> 0x00, each with rd_valid one cycle after ce.
- Access during fill: ce=1, wre=1, ad=3, din=0xAA while busy -> ignored; after fill, read ad=3 -> 0x0C.
- Reset mid-fill: pulse reset at fill cycle 7 -> busy stays high 16 more cycles; read ad=7 -> 0x08.
- Byte enables (DATA_W=16, WRITE_MODE=0): write ad=2, din=0xBEEF, be=2'b10 over init word 0x000D -> read gives 0xBE0D; dout unchanged on the write cycle.
- Write modes (8-bit, ad=5 holding 0x0A, write din=0x55):
  - WRITE_MODE=1 -> dout=0x55, rd_valid=1;
  - WRITE_MODE=2 -> dout=0x0A, rd_valid=1;
  - following read -> 0x55.
- Pipeline (READ_MODE=1): reads ad=0,1 back-to-back with oce=1 -> 0x0F then 0x0E, each 2 cycles after its ce. With oce=0 for 3 cycles after the second read -> dout holds and rd_valid=0; raising oce -> 0x0E presented, rd_valid pulses once.
